alu_result_display: RTL and testbench
=====================================

# alu_result_display

Receiving end of the 4-bit ALU result bus. Captures the ALU's 5-bit `RESULT` and `COUT` on a load strobe and converts the result to BCD with a sequential shift-add-3 engine. Drives a 4-digit, time-multiplexed, common-anode 7-segment display on the board. Sits between the ALU and the board's display pins.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles per digit slot in the display scan (≥2).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  capture strobe; sampled only when idle.
- `result`  in  5  ALU `RESULT` bus.
- `cout`  in  1  ALU carry-out.
- `busy`  out  1  high while a conversion is in flight.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `an`  out  4  digit enables, one-hot active-low; `an[0]` is the rightmost digit.
- `dp`  out  1  decimal point, active-low; held at 1 (off).

## Operation
- FSM states:
  - IDLE: `load`=1 captures `result`/`cout`, clears the counter and BCD registers, and goes to CONV.
  - CONV: performs 5 shift-add-3 iterations, one per clock, MSB first. Before each shift, any BCD nibble ≥5 gets +3. After the 5th iteration, goes to COMMIT.
  - COMMIT: copies tens, ones and carry flag into the display registers, then returns to IDLE.
- Magnitude range is 0..31, so the conversion needs a 4-bit ones nibble and a 2-bit tens nibble.
- `load` is ignored in CONV and COMMIT; there is no queueing.
- Digit content:
  - digit0: ones value.
  - digit1: tens value, blanked when the tens value is 0 (leading-zero suppression).
  - digit2: blank.
  - digit3: 'C' if the captured `cout`=1, otherwise blank.
- Scan:
  - A prescaler counts 0..`SCAN_DIV`-1. When it wraps, the 2-bit digit index increments 0→1→2→3→0.
  - `an` and `seg` are decoded combinationally from the digit index and the display registers.
- Glyphs (active-low):
  - '0'=1000000, '1'=1111001, '2'=0100100, '3'=0110000, '4'=0011001
  - '5'=0010010, '6'=0000010, '7'=1111000, '8'=0000000, '9'=0010000
  - 'C'=1000110, '-'=0111111, blank=1111111
- Reset (async, any state, including mid-conversion):
  - FSM goes to IDLE; `busy`=0.
  - Display registers hold value 0 with the carry flag cleared.
  - Prescaler and digit index are 0.
  - Resulting outputs: `an`=1110, `seg`=1000000, `dp`=1.

## Timing
- If `load`=1 at clock edge k in IDLE:
  - `busy`=1 after edge k.
  - The 5 CONV iterations occur at edges k+1..k+5.
  - COMMIT occurs at edge k+6: the display registers update and `busy`=0 after edge k+6.
- Latency from the capture edge to the new digits is 6 cycles.
- The earliest next capture is at edge k+7.
- `result`/`cout` only need to be stable at the capture edge.
- Scan period is 4·`SCAN_DIV` cycles. The scan is unaffected by load or conversion activity; the display switches to the new value mid-scan at COMMIT.

## Configuration
- `ALU_DISP_SIGNED_EN` defined:
  - `result` is interpreted as two's-complement, range −16..+15.
  - Magnitude is computed at capture; the maximum magnitude is 16.
  - digit2 shows '-' when the value is negative, otherwise blank.
  - Latency is unchanged.
- Not defined: `result` is unsigned 0..31 and digit2 is always blank.

## Structure
- Package `alu_disp_pkg`:
  - FSM state enum (IDLE/CONV/COMMIT).
  - 7-bit glyph constants for 0–9, 'C', '-' and blank.
  - Digit index width.
- Sub-module `alu_bcd_conv`: the sequential 5-bit-to-BCD engine, with start/done handshake and tens/ones outputs.
- The top level holds capture, display registers, scan prescaler and glyph decode.

## Test plan
Run with `SCAN_DIV`=4.
- Reset: assert `rst_n`=0 → `an`=1110, `seg`=1000000, `busy`=0, `dp`=1. Repeat mid-scan with the same required result.
- Two-digit conversion: `load` with `result`=23, `cout`=0 → `busy` high for exactly 6 cycles; then digit0=0110000, digit1=0100100, digit2 and digit3=1111111.
- Carry and zero suppression:
  - `result`=31, `cout`=1 → digit3=1000110 ('C'), digit1='3', digit0='1'.
  - `result`=7 → digit1 blank.
- Busy lockout: `load` `result`=5, then `load` `result`=9 two cycles later → display shows '5' and only one 6-cycle `busy` pulse occurs. Reset asserted at cycle 3 of a conversion → display returns to '0'.
- Scan order: observe 20 cycles → `an` sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
- Signed mode: `result`=11101 → with `ALU_DISP_SIGNED_EN`, digit2='-', digit1 blank, digit0='3'. Without it, digits show '29'.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// Shared types and glyph constants for the ALU result display.
// Optional signed display mode is selected with ALU_DISP_SIGNED_EN.
package alu_disp_pkg;

    localparam int unsigned DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] digit_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/alu_bcd_conv.sv
// Sequential 5-bit binary to BCD converter (shift-add-3, one bit per clock).
// start_i is taken only in IDLE; done_o pulses for the single COMMIT cycle.
module alu_bcd_conv
    import alu_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [4:0] bin_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] tens_o,
    output logic [3:0] ones_o
);

    conv_state_e state_q;
    logic [2:0]  cnt_q;
    logic [4:0]  bin_q;
    logic [1:0]  tens_q;
    logic [3:0]  ones_q;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  ones_adj;

    // Tens never exceeds 3 for a 5-bit input, so only the ones nibble needs the +3 fix-up.
    always_comb begin
        ones_adj = ones_q;
        if (ones_q >= 4'd5) begin
            ones_adj = ones_q + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q   <= bin_i;
                        tens_q  <= '0;
                        ones_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bin_q  <= {bin_q[3:0], 1'b0};
                    tens_q <= {tens_q[0], ones_adj[3]};
                    ones_q <= {ones_adj[2:0], bin_q[4]};
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd4) begin
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/alu_result_display.sv
// ALU result capture, BCD conversion and 4-digit multiplexed 7-segment drive.
// Define ALU_DISP_SIGNED_EN to show result as two's-complement with a '-' on digit2.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] result,
    input  logic       cout,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic               conv_busy;
    logic               conv_done;
    logic [1:0]         conv_tens;
    logic [3:0]         conv_ones;
    logic               start;
    logic [4:0]         mag;

    logic               carry_cap_q;
    logic [1:0]         disp_tens_q;
    logic [3:0]         disp_ones_q;
    logic               disp_carry_q;
    logic [PW-1:0]      presc_q, presc_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;

    assign start = load & ~conv_busy;

`ifdef ALU_DISP_SIGNED_EN
    logic neg_cap_q;
    logic disp_neg_q;

    // -16 negates to 5'b10000, which is still the correct unsigned magnitude.
    assign mag = result[4] ? (~result + 5'd1) : result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_cap_q  <= 1'b0;
            disp_neg_q <= 1'b0;
        end else begin
            if (start) begin
                neg_cap_q <= result[4];
            end
            if (conv_done) begin
                disp_neg_q <= neg_cap_q;
            end
        end
    end
`else
    assign mag = result;
`endif

    alu_bcd_conv u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .bin_i   (mag),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .tens_o  (conv_tens),
        .ones_o  (conv_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cap_q  <= 1'b0;
            disp_tens_q  <= '0;
            disp_ones_q  <= '0;
            disp_carry_q <= 1'b0;
        end else begin
            if (start) begin
                carry_cap_q <= cout;
            end
            if (conv_done) begin
                disp_tens_q  <= conv_tens;
                disp_ones_q  <= conv_ones;
                disp_carry_q <= carry_cap_q;
            end
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        digit_d = digit_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            digit_d = digit_q + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            digit_q <= '0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        an  = ~(4'b0001 << digit_q);
        seg = GLYPH_BLANK;
        case (digit_q)
            2'd0: seg = digit_glyph(disp_ones_q);
            2'd1: seg = (disp_tens_q == 2'd0) ? GLYPH_BLANK : digit_glyph({2'b00, disp_tens_q});
`ifdef ALU_DISP_SIGNED_EN
            2'd2: seg = disp_neg_q ? GLYPH_DASH : GLYPH_BLANK;
`else
            2'd2: seg = GLYPH_BLANK;
`endif
            default: seg = disp_carry_q ? GLYPH_C : GLYPH_BLANK;
        endcase
    end

    assign busy = conv_busy;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed scoreboard bench for alu_result_display (SCAN_DIV=4); honours ALU_DISP_SIGNED_EN.
module tb_alu_result_display;

    localparam int unsigned SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [4:0] result = '0;
    logic       cout = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [27:0] digits;
    } exp_t;

    exp_t sb[$];

    alu_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .result (result),
        .cout   (cout),
        .busy   (busy),
        .seg    (seg),
        .an     (an),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] tb_glyph(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {digit3,digit2,digit1,digit0} for a captured result/cout.
    function automatic logic [27:0] model(input logic [4:0] r, input logic c);
        int v;
        logic neg;
`ifdef ALU_DISP_SIGNED_EN
        v = int'($signed(r));
`else
        v = int'(r);
`endif
        neg = (v < 0);
        if (neg) v = -v;
        return {c ? 7'b1000110 : 7'b1111111,
                neg ? 7'b0111111 : 7'b1111111,
                (v / 10 == 0) ? 7'b1111111 : tb_glyph(v / 10),
                tb_glyph(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_digits(output logic [27:0] got);
        logic [3:0] seen;
        got  = 'x;
        seen = '0;
        for (int i = 0; i < 64; i++) begin
            case (an)
                4'b1110: begin got[6:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin got[13:7]  = seg; seen[1] = 1'b1; end
                4'b1011: begin got[20:14] = seg; seen[2] = 1'b1; end
                4'b0111: begin got[27:21] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
            if (seen == 4'b1111) break;
            @(negedge clk);
        end
    endtask

    task automatic compare_next();
        exp_t e;
        logic [27:0] got;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            read_digits(got);
            check(e.tag, 32'(got), 32'(e.digits));
        end
    endtask

    task automatic do_load(input string tag, input logic [4:0] r, input logic c);
        int n;
        @(negedge clk);
        load = 1'b1; result = r; cout = c;
        sb.push_back('{tag, model(r, c)});
        @(negedge clk);
        load = 1'b0; result = 5'($urandom); cout = 1'($urandom);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        check({tag, "_busy"}, 32'(n), 32'd6);
        compare_next();
    endtask

    initial begin
        int hi;
        int pulses;
        logic prev;

        // Reset state
        #12;
        check("rst_an", 32'(an), 32'b1110);
        check("rst_seg", 32'(seg), 32'b1000000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dp", 32'(dp), 32'd1);

        // Scan order from release
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("scan_an%0d", i), 32'(an), 32'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
            @(negedge clk);
        end

        // Mid-scan reset
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_an", 32'(an), 32'b1110);
        check("mrst_seg", 32'(seg), 32'b1000000);
        check("mrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_load("r23", 5'd23, 1'b0);
        do_load("r31c", 5'd31, 1'b1);
        do_load("r7", 5'd7, 1'b0);

        // Busy lockout: second load two cycles later is ignored
        @(negedge clk);
        load = 1'b1; result = 5'd5; cout = 1'b0;
        sb.push_back('{"lock5", model(5'd5, 1'b0)});
        @(negedge clk);
        load = 1'b0;
        hi = 0; pulses = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin load = 1'b1; result = 5'd9; end
            if (i == 2) load = 1'b0;
            if (busy && !prev) pulses++;
            if (busy) hi++;
            prev = busy;
            @(negedge clk);
        end
        check("lock_hi", 32'(hi), 32'd6);
        check("lock_pulses", 32'(pulses), 32'd1);
        compare_next();

        // Reset during the third conversion cycle
        @(negedge clk);
        load = 1'b1; result = 5'd14; cout = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        sb.push_back('{"rst_conv", model(5'd0, 1'b0)});
        #1;
        check("rconv_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_next();

        do_load("r29_or_m3", 5'b11101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
